bt656_rx: RTL and testbench

Receive-side counterpart of the BT.656 serializer: takes the 8-bit multiplexed stream (Cb,Y,Cr,Y with FF-00-00-XY timing reference codes) on a single system clock with a byte-valid strobe and recovers decoded F/V/H flags, a 4:2:2 pixel stream and line/pixel position. Sits directly behind the input pad/sampling logic and feeds the video capture/scaler path.

---
 rtl/bt656_rx.sv | 182 ++++++++++++++++++
 tb/tb_bt656_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bt656_rx.sv
// bt656_rx: BT.656 byte-stream decoder recovering F/V/H, 4:2:2 pixels and line/pixel position.
// Define BT656_RX_ERRCHK_EN to reject XY codes whose bit7/protection bits are inconsistent.
module bt656_rx #(
  parameter int HACT_BYTES = 1440,
  parameter int LINE_W     = 10,
  parameter int PIX_W      = $clog2(HACT_BYTES/2)
) (
  input  logic              i_SysClock,
  input  logic              i_Reset,
  input  logic              i_DataValid,
  input  logic [7:0]        i_Data,
  output logic [7:0]        o_Y,
  output logic [7:0]        o_C,
  output logic              o_CbNCr,
  output logic              o_PixValid,
  output logic [PIX_W-1:0]  o_PixelCount,
  output logic [LINE_W-1:0] o_LineCount,
  output logic              o_Fsignal,
  output logic              o_Vsignal,
  output logic              o_Hsignal,
  output logic              o_LineStart,
  output logic              o_FieldStart,
  output logic              o_SyncErr,
  output logic              o_LenErr
);
  localparam logic [2:0] SEARCH = 3'd0, PRE1 = 3'd1, PRE2 = 3'd2, PRE3 = 3'd3, ACTIVE = 3'd4;
  localparam int BC_W = $clog2(HACT_BYTES + 2);
  localparam logic [BC_W-1:0] HB  = BC_W'(HACT_BYTES);
  localparam logic [BC_W-1:0] HB1 = BC_W'(HACT_BYTES + 1);
  logic              dv_q;
  logic [7:0]        d_q;
  logic [2:0]        st_q, st_d;
  logic [1:0]        ph_q, ph_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [PIX_W-1:0]  pix_q, pix_d, pc_q, pc_d;
  logic              in_line_q, in_line_d;
  logic [7:0]        cl_q, cl_d, y_q, y_d, c_q, c_d;
  logic              cbncr_q, cbncr_d, pv_q, pv_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              f_q, f_d, v_q, v_d, h_q, h_d;
  logic              ls_q, ls_d, fs_q, fs_d, se_q, se_d, le_q, le_d;
  logic              ff, zz, xf, xv, xh, xy_ok;
  assign ff = d_q == 8'hFF;
  assign zz = d_q == 8'h00;
  assign {xf, xv, xh} = d_q[6:4];
`ifdef BT656_RX_ERRCHK_EN
  assign xy_ok = d_q[7] && d_q[3:0] == {xv ^ xh, xf ^ xh, xf ^ xv, xf ^ xv ^ xh};
`else
  assign xy_ok = 1'b1;
`endif
  always_comb begin
    st_d = st_q;
    ph_d = ph_q;
    bc_d = bc_q;
    pix_d = pix_q;
    pc_d = pc_q;
    in_line_d = in_line_q;
    cl_d = cl_q;
    y_d = y_q;
    c_d = c_q;
    cbncr_d = cbncr_q;
    line_d = line_q;
    f_d = f_q;
    v_d = v_q;
    h_d = h_q;
    pv_d = 1'b0;
    ls_d = 1'b0;
    fs_d = 1'b0;
    se_d = 1'b0;
    le_d = 1'b0;
    if (dv_q) begin
      case (st_q)
        PRE1: begin
          st_d = zz ? PRE2 : ff ? PRE1 : SEARCH;
          se_d = !zz && !ff;
        end
        PRE2: begin
          st_d = zz ? PRE3 : SEARCH;
          se_d = !zz;
        end
        PRE3: begin
          st_d = SEARCH;
          se_d = !xy_ok;
          if (xy_ok) begin
            {f_d, v_d, h_d} = {xf, xv, xh};
            if (xh) begin
              fs_d = xf != f_q;
              line_d = fs_d ? '0 : line_q + 1'b1;
              le_d = in_line_q && bc_q != HB;
            end else if (!xv) begin
              st_d = ACTIVE;
              ph_d = 2'd0;
              bc_d = '0;
              pix_d = '0;
              ls_d = 1'b1;
              in_line_d = 1'b1;
            end
          end
        end
        ACTIVE: begin
          st_d = ff ? PRE1 : ACTIVE;
          if (!ff) begin
            ph_d = ph_q + 2'd1;
            bc_d = bc_q == HB1 ? bc_q : bc_q + 1'b1;
            cl_d = ph_q[0] ? cl_q : d_q;
            // odd phases carry luma; pair it with whichever chroma was latched just before
            if (ph_q[0]) begin
              y_d = d_q;
              c_d = cl_q;
              cbncr_d = !ph_q[1];
              pc_d = pix_q;
              pix_d = pix_q + 1'b1;
              pv_d = 1'b1;
            end
          end
        end
        default: st_d = ff ? PRE1 : SEARCH;
      endcase
      if (st_d == SEARCH) in_line_d = 1'b0;
    end
  end
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      dv_q <= 1'b0;
      d_q <= 8'h00;
      st_q <= SEARCH;
      ph_q <= 2'd0;
      bc_q <= '0;
      pix_q <= '0;
      pc_q <= '0;
      in_line_q <= 1'b0;
      cl_q <= 8'h00;
      y_q <= 8'h00;
      c_q <= 8'h00;
      cbncr_q <= 1'b1;
      pv_q <= 1'b0;
      line_q <= '0;
      f_q <= 1'b0;
      v_q <= 1'b1;
      h_q <= 1'b1;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      se_q <= 1'b0;
      le_q <= 1'b0;
    end else begin
      dv_q <= i_DataValid;
      d_q <= i_Data;
      st_q <= st_d;
      ph_q <= ph_d;
      bc_q <= bc_d;
      pix_q <= pix_d;
      pc_q <= pc_d;
      in_line_q <= in_line_d;
      cl_q <= cl_d;
      y_q <= y_d;
      c_q <= c_d;
      cbncr_q <= cbncr_d;
      pv_q <= pv_d;
      line_q <= line_d;
      f_q <= f_d;
      v_q <= v_d;
      h_q <= h_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      se_q <= se_d;
      le_q <= le_d;
    end
  end
  assign o_Y = y_q;
  assign o_C = c_q;
  assign o_CbNCr = cbncr_q;
  assign o_PixValid = pv_q;
  assign o_PixelCount = pc_q;
  assign o_LineCount = line_q;
  assign o_Fsignal = f_q;
  assign o_Vsignal = v_q;
  assign o_Hsignal = h_q;
  assign o_LineStart = ls_q;
  assign o_FieldStart = fs_q;
  assign o_SyncErr = se_q;
  assign o_LenErr = le_q;
endmodule

// File: tb/tb_bt656_rx.sv
// tb_bt656_rx: randomized self-checking bench for bt656_rx against a byte-stream parser model.
module tb_bt656_rx;
  localparam int HACT = 1440;
  localparam int PIX_W = 10;
  logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] y, c;
  logic cbncr, pv, fo, vo, ho, ls, fs, se, le;
  logic [PIX_W-1:0] pc;
  logic [9:0] lc;
  always #5 clk = ~clk;
  bt656_rx dut (
    .i_SysClock(clk), .i_Reset(rst), .i_DataValid(dv), .i_Data(din),
    .o_Y(y), .o_C(c), .o_CbNCr(cbncr), .o_PixValid(pv), .o_PixelCount(pc),
    .o_LineCount(lc), .o_Fsignal(fo), .o_Vsignal(vo), .o_Hsignal(ho),
    .o_LineStart(ls), .o_FieldStart(fs), .o_SyncErr(se), .o_LenErr(le)
  );
  int n_tests = 0, n_fail = 0;
  logic [7:0] stim[$];
  logic [31:0] exp_q[$];
  logic [31:0] pix_log[$];
  int n_ls = 0, n_fs = 0, n_le = 0, n_se = 0, n_dbl = 0;
  logic p_ls = 0, p_fs = 0, p_le = 0, p_se = 0;
  int m_f, m_v, m_h, m_line, m_ls = 0, m_fs = 0, m_le = 0, m_se = 0, m_cnt = 0, m_pix = 0;
  bit m_act;
  logic [7:0] m_cb = 0, m_cr = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (pv) begin
      pix_log.push_back({5'b0, y, c, cbncr, pc});
      if (exp_q.size() == 0) check("pix_extra", 1, 0);
      else check("pix", {5'b0, y, c, cbncr, pc}, exp_q.pop_front());
    end
    n_dbl += int'((ls && p_ls) || (fs && p_fs) || (le && p_le) || (se && p_se));
    n_ls += int'(ls);
    n_fs += int'(fs);
    n_le += int'(le);
    n_se += int'(se);
    {p_ls, p_fs, p_le, p_se} = {ls, fs, le, se};
  end
  function automatic bit xy_valid(input logic [7:0] x);
`ifdef BT656_RX_ERRCHK_EN
    return x[7] && x[3] == (x[5] ^ x[4]) && x[2] == (x[6] ^ x[4]) &&
           x[1] == (x[6] ^ x[5]) && x[0] == (x[6] ^ x[5] ^ x[4]);
`else
    return 1'b1;
`endif
  endfunction
  function automatic void model_reset();
    m_f = 0; m_v = 1; m_h = 1; m_line = 0; m_act = 0;
  endfunction
  task automatic model_run();
    int i, j, n;
    bit was;
    logic [7:0] b, xy;
    i = 0;
    n = stim.size();
    while (i < n) begin
      b = stim[i];
      if (b == 8'hFF) begin
        was = m_act;
        m_act = 0;
        j = i;
        while (j < n && stim[j] == 8'hFF) j++;
        if (j + 2 >= n) break;
        if (stim[j] != 8'h00) begin m_se++; i = j + 1; continue; end
        if (stim[j+1] != 8'h00) begin m_se++; i = j + 2; continue; end
        xy = stim[j+2];
        i = j + 3;
        if (!xy_valid(xy)) begin m_se++; continue; end
        if (xy[4]) begin
          if (was && m_cnt != HACT) m_le++;
          if (int'(xy[6]) != m_f) begin m_fs++; m_line = 0; end
          else m_line = (m_line + 1) % 1024;
        end else if (!xy[5]) begin
          m_act = 1; m_cnt = 0; m_pix = 0; m_ls++;
        end
        m_f = int'(xy[6]); m_v = int'(xy[5]); m_h = int'(xy[4]);
      end else begin
        if (m_act) begin
          if (m_cnt % 4 == 0) m_cb = b;
          else if (m_cnt % 4 == 2) m_cr = b;
          else begin
            exp_q.push_back({5'b0, b, (m_cnt % 4 == 1) ? m_cb : m_cr, m_cnt % 4 == 1, 10'(m_pix % 1024)});
            m_pix++;
          end
          m_cnt++;
        end
        i++;
      end
    end
  endtask
  task automatic add_pre(input logic [7:0] xy);
    stim.push_back(8'hFF); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(xy);
  endtask
  task automatic add_data(input int nb, input bit rnd);
    logic [7:0] pat[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int k = 0; k < nb; k++) stim.push_back(rnd ? 8'($urandom_range(1, 254)) : pat[k % 4]);
  endtask
  task automatic send(input bit gaps);
    foreach (stim[k]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk); dv = 1'b0; din = 8'($urandom);
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      @(negedge clk); dv = 1'b1; din = stim[k];
    end
    @(negedge clk); dv = 1'b0;
  endtask
  task automatic run(input string tag, input bit gaps);
    pix_log.delete();
    model_run();
    send(gaps);
    repeat (6) @(negedge clk);
    stim.delete();
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_ls"}, n_ls, m_ls);
    check({tag, "_fs"}, n_fs, m_fs);
    check({tag, "_le"}, n_le, m_le);
    check({tag, "_se"}, n_se, m_se);
    check({tag, "_fvh"}, {fo, vo, ho}, {m_f[0], m_v[0], m_h[0]});
    check({tag, "_line"}, lc, m_line);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_y"}, y, 0);
    check({tag, "_c"}, c, 0);
    check({tag, "_flags"}, {cbncr, pv, fo, vo, ho, ls, fs, se, le}, 9'b100110000);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_lc"}, lc, 0);
  endtask
  initial begin
    logic [31:0] last;
    int le0, ls0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst0");
    add_pre(8'h80); add_data(HACT, 0); add_pre(8'h9D);
    run("t1", 0);
    check("t1_npix", pix_log.size(), 720);
    if (pix_log.size() == 720) begin
      last = pix_log[719];
      check("t1_p0", pix_log[0], {5'b0, 8'h20, 8'h10, 1'b1, 10'd0});
      check("t1_p1", pix_log[1], {5'b0, 8'h40, 8'h30, 1'b0, 10'd1});
      check("t1_last_pc", last[9:0], 719);
    end
    check("t1_lc", lc, 1);
    add_pre(8'hAB); add_data(20, 1); add_pre(8'hB6); add_data(8, 1);
    run("blank", 0);
    check("blank_v", vo, 1);
    check("blank_npix", pix_log.size(), 0);
    ls0 = n_ls;
    add_pre(8'h80); add_data(HACT, 1); add_pre(8'h9D);
    run("t2", 0);
    check("t2_ls", n_ls - ls0, 1);
    ls0 = n_ls;
    add_pre(8'h81); add_data(16, 1);
    run("xy81", 0);
`ifdef BT656_RX_ERRCHK_EN
    check("xy81_ls", n_ls - ls0, 0);
`else
    check("xy81_ls", n_ls - ls0, 1);
`endif
    le0 = n_le;
    add_pre(8'h80); add_data(HACT - 4, 1); add_pre(8'h9D);
    run("short", 0);
    check("short_le", n_le - le0, 1);
    le0 = n_le;
    add_pre(8'h80); add_data(HACT, 1); add_pre(8'h9D); add_pre(8'hDA);
    run("field", 0);
    check("field_le", n_le - le0, 0);
    check("field_f", fo, 1);
    check("field_lc", lc, 0);
    add_pre(8'hC7); add_data(8, 1); add_pre(8'hDA);
    run("f1", 0);
    add_pre(8'h80); add_data(HACT, 0); add_pre(8'h9D);
    run("gaps", 1);
    check("gaps_npix", pix_log.size(), 720);
    stim.push_back(8'hFF); stim.push_back(8'h12);
    stim.push_back(8'hFF); stim.push_back(8'h00); stim.push_back(8'h34);
    add_data(4, 1);
    run("brk", 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 300; k++) begin
        case ($urandom_range(0, 15))
          0: add_pre(8'($urandom));
          1: add_pre(8'h80);
          2: stim.push_back(8'hFF);
          3: stim.push_back(8'h00);
          default: stim.push_back(8'($urandom));
        endcase
      end
      add_data(4, 1);
      run("rnd", r[0]);
    end
    add_pre(8'h80); add_data(602, 0);
    run("mid", 0);
    last = pix_log.size() > 0 ? pix_log[pix_log.size() - 1] : 32'hFFFF_FFFF;
    check("mid_pc", last[9:0], 300);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    check_reset("rst1");
    add_data(40, 1); add_pre(8'h80); add_data(HACT, 1); add_pre(8'h9D);
    run("resume", 0);
    check("resume_npix", pix_log.size(), 720);
    check("pulse_width", n_dbl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
